// File: rtl/resonator_dds_hls_deadlock_monitor_param.sv
// rtl/resonator_dds_hls_deadlock_monitor_param.sv - persistence-filtered deadlock monitor for the resonator_dds dataflow region
module resonator_dds_hls_deadlock_monitor_param #(
    parameter int NUM_AXIS    = 2,
    parameter int NUM_INST    = 1,
    parameter int HOLD_CYCLES = 16,
    parameter int STICKY      = 1,
    parameter int CNT_W       = 16,
    localparam int FA_W       = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                block,
    output logic [NUM_AXIS-1:0] axis_block_info,
    output logic [NUM_INST-1:0] inst_block_info,
    output logic [FA_W-1:0]     first_axis,
    output logic                first_axis_vld,
    output logic [CNT_W-1:0]    block_cycles
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WATCH   = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;

    logic [1:0]      state;
    logic [HC_W-1:0] hcnt;
    logic            inst_dl;
    logic            cand;
    logic [FA_W-1:0] low_idx;
    logic            enter;
    logic            reload;
    logic            leave;

    // All-idle is never a deadlock: at least one instance must report blocked.
    assign inst_dl = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
    assign cand    = (|axis_block_sigs) | inst_dl;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) low_idx = FA_W'(i);
        end
    end

    assign enter  = cand && (((state == S_IDLE) && (HOLD_CYCLES == 1)) ||
                             ((state == S_WATCH) && (hcnt == HOLD_LAST)));
    assign reload = enter || ((state == S_BLOCKED) && (STICKY == 0) && cand);
    assign leave  = clear || ((state == S_BLOCKED) && (STICKY == 0) && !cand);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            hcnt  <= '0;
        end else if (clear) begin
            state <= S_IDLE;
            hcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cand) begin
                        hcnt  <= HC_W'(1);
                        state <= (HOLD_CYCLES == 1) ? S_BLOCKED : S_WATCH;
                    end
                end
                S_WATCH: begin
                    if (!cand) begin
                        state <= S_IDLE;
                        hcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + HC_W'(1);
                        if (hcnt == HOLD_LAST) state <= S_BLOCKED;
                    end
                end
                S_BLOCKED: begin
                    if ((STICKY == 0) && !cand) begin
                        state <= S_IDLE;
                        hcnt  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

    // Report registers: zero outside BLOCKED, captured on entry, reloaded live when not sticky.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block           <= 1'b0;
            axis_block_info <= '0;
            inst_block_info <= '0;
            first_axis      <= '0;
            first_axis_vld  <= 1'b0;
            block_cycles    <= '0;
        end else if (leave) begin
            block           <= 1'b0;
            axis_block_info <= '0;
            inst_block_info <= '0;
            first_axis      <= '0;
            first_axis_vld  <= 1'b0;
            block_cycles    <= '0;
        end else begin
            if (reload) begin
                block           <= 1'b1;
                axis_block_info <= axis_block_sigs;
                inst_block_info <= inst_dl ? inst_block_sigs : '0;
                first_axis      <= low_idx;
                first_axis_vld  <= |axis_block_sigs;
            end
            if (enter) begin
                block_cycles <= CNT_W'(1);
            end else if ((state == S_BLOCKED) && (block_cycles != CNT_MAX)) begin
                block_cycles <= block_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_resonator_dds_hls_deadlock_monitor_param.sv
// tb/tb_resonator_dds_hls_deadlock_monitor_param.sv - directed bench for the deadlock monitor
module tb_resonator_dds_hls_deadlock_monitor_param;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       a_clear = 1'b0, b_clear = 1'b0;
    logic [1:0] a_axis = '0, b_axis = '0;
    logic [1:0] a_idle = '0, a_blk = '0;
    logic [0:0] b_idle = '0, b_blk = '0;

    logic       a_block, a_vld, b_block, b_vld;
    logic [1:0] a_axis_info, b_axis_info, a_inst_info;
    logic [0:0] b_inst_info, a_first, b_first;
    logic [3:0] a_cycles;
    logic [15:0] b_cycles;

    int tests = 0;
    int failed = 0;

    always #5 clock = ~clock;

    // Sticky, two instances, 4-bit saturating counter, HOLD 16.
    resonator_dds_hls_deadlock_monitor_param #(
        .NUM_AXIS(2), .NUM_INST(2), .HOLD_CYCLES(16), .STICKY(1), .CNT_W(4)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .clear(a_clear),
        .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle), .inst_block_sigs(a_blk),
        .block(a_block), .axis_block_info(a_axis_info), .inst_block_info(a_inst_info),
        .first_axis(a_first), .first_axis_vld(a_vld), .block_cycles(a_cycles)
    );

    // Live-follow, single-cycle detection.
    resonator_dds_hls_deadlock_monitor_param #(
        .NUM_AXIS(2), .NUM_INST(1), .HOLD_CYCLES(1), .STICKY(0), .CNT_W(16)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .clear(b_clear),
        .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle), .inst_block_sigs(b_blk),
        .block(b_block), .axis_block_info(b_axis_info), .inst_block_info(b_inst_info),
        .first_axis(b_first), .first_axis_vld(b_vld), .block_cycles(b_cycles)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("a_reset_async_block", 32'(a_block), 0);
        tick(2);
        chk("a_reset_block", 32'(a_block), 0);
        chk("a_reset_cycles", 32'(a_cycles), 0);
        chk("a_reset_info", 32'(a_axis_info), 0);
        chk("b_reset_block", 32'(b_block), 0);
        chk("b_reset_cycles", 32'(b_cycles), 0);
        reset_n = 1'b1;

        // Transient stall of 15 edges must be filtered.
        a_axis = 2'b10;
        tick(15);
        chk("t1_15_edges", 32'(a_block), 0);
        a_axis = 2'b00;
        tick();
        chk("t1_dropped", 32'(a_block), 0);

        // 16 consecutive edges assert block.
        a_axis = 2'b10;
        tick(15);
        chk("t2_edge15", 32'(a_block), 0);
        tick();
        chk("t2_block", 32'(a_block), 1);
        chk("t2_axis_info", 32'(a_axis_info), 2);
        chk("t2_first_axis", 32'(a_first), 1);
        chk("t2_first_vld", 32'(a_vld), 1);
        chk("t2_cycles1", 32'(a_cycles), 1);
        tick();
        chk("t2_cycles2", 32'(a_cycles), 2);

        // Sticky report survives the stall going away; clear drops it.
        a_axis = 2'b00;
        tick();
        chk("t3_hold_block", 32'(a_block), 1);
        chk("t3_hold_info", 32'(a_axis_info), 2);
        chk("t3_hold_cycles", 32'(a_cycles), 3);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("t3_clr_block", 32'(a_block), 0);
        chk("t3_clr_info", 32'(a_axis_info), 0);
        chk("t3_clr_first", 32'(a_first), 0);
        chk("t3_clr_vld", 32'(a_vld), 0);
        chk("t3_clr_cycles", 32'(a_cycles), 0);
        tick();
        chk("t3_idle_block", 32'(a_block), 0);

        // Counter saturation at 15 with CNT_W=4.
        a_axis = 2'b01;
        tick(16);
        chk("t6_block", 32'(a_block), 1);
        chk("t6_first_axis0", 32'(a_first), 0);
        chk("t6_cycles1", 32'(a_cycles), 1);
        tick(19);
        chk("t6_saturated", 32'(a_cycles), 15);

        // Clear with cand still high: the next edge starts a fresh run.
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("clr_cand_block", 32'(a_block), 0);
        chk("clr_cand_cycles", 32'(a_cycles), 0);
        tick(15);
        chk("clr_cand_edge15", 32'(a_block), 0);
        tick();
        chk("clr_cand_edge16", 32'(a_block), 1);
        a_axis = 2'b00;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;

        // Instance deadlock: one blocked, the other idle.
        a_idle = 2'b01;
        a_blk = 2'b10;
        tick(16);
        chk("t5_block", 32'(a_block), 1);
        chk("t5_inst_info", 32'(a_inst_info), 2);
        chk("t5_axis_info", 32'(a_axis_info), 0);
        chk("t5_vld", 32'(a_vld), 0);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        a_idle = 2'b11;
        a_blk = 2'b00;
        tick(20);
        chk("t5_all_idle", 32'(a_block), 0);
        a_idle = 2'b00;

        // Async reset while blocked clears outputs without a clock edge.
        a_axis = 2'b10;
        tick(16);
        chk("t6_pre_reset_block", 32'(a_block), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_block", 32'(a_block), 0);
        chk("t6_async_cycles", 32'(a_cycles), 0);
        chk("t6_async_info", 32'(a_axis_info), 0);
        #1 reset_n = 1'b1;

        // Reset mid-WATCH restarts the count.
        tick(10);
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick(15);
        chk("t6_fresh_edge15", 32'(a_block), 0);
        tick();
        chk("t6_fresh_edge16", 32'(a_block), 1);
        a_axis = 2'b00;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;

        // Non-sticky, HOLD 1: single-edge detection and live reload.
        b_axis = 2'b10;
        tick();
        chk("t4_block", 32'(b_block), 1);
        chk("t4_info10", 32'(b_axis_info), 2);
        chk("t4_first1", 32'(b_first), 1);
        chk("t4_cycles1", 32'(b_cycles), 1);
        b_axis = 2'b11;
        tick();
        chk("t4_info11", 32'(b_axis_info), 3);
        chk("t4_first0", 32'(b_first), 0);
        chk("t4_cycles2", 32'(b_cycles), 2);
        b_axis = 2'b00;
        tick();
        chk("t4_drop_block", 32'(b_block), 0);
        chk("t4_drop_info", 32'(b_axis_info), 0);
        chk("t4_drop_cycles", 32'(b_cycles), 0);
        b_blk = 1'b1;
        tick();
        chk("b_inst_block", 32'(b_block), 1);
        chk("b_inst_info", 32'(b_inst_info), 1);
        b_blk = 1'b0;
        b_idle = 1'b1;
        tick();
        chk("b_idle_only", 32'(b_block), 0);
        chk("b_idle_info", 32'(b_inst_info), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
